// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-load stream of the instruction ROM loader, grouped as one bundle.
// The driving side (core fetch + program source) uses master; the loader uses slave.
interface inst_rom_loader_if;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  // Load stream: a byte (with ld_last_i) transfers on a rising edge where
  // ld_valid_i && ld_ready_o; the source holds byte/last stable while valid is high.
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [7:0]  ld_byte_i;
  logic        ld_last_i;

  modport master (
    output ce_i, addr_i, ld_valid_i, ld_byte_i, ld_last_i,
    input  inst_o, ld_ready_o
  );

  modport slave (
    input  ce_i, addr_i, ld_valid_i, ld_byte_i, ld_last_i,
    output inst_o, ld_ready_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM filled from a big-endian byte stream; holds the core in reset
// until the program is loaded, then serves zero-latency fetches.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_rom_loader_if.slave      bus,
  input  logic                  reload_i,
  output logic                  core_rst_o,
  output logic                  ld_done_o,
  output logic                  ld_err_o,
  output logic [DEPTH_LOG2:0]   word_cnt_o,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic        ready_q;
  logic        accept;
  logic        full;
  logic        wr_en;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_in_range;
  logic                  rd_hit;
  logic                  unused_addr;

  assign accept    = bus.ld_valid_i && ready_q;
  assign full      = (word_cnt_o == FULL_CNT);
  assign wr_en     = accept && !full && (bus.ld_last_i || (byte_cnt == 2'd3));
  assign state_dbg = state;
  assign bus.ld_ready_o = ready_q;

  // asm_q is cleared at every word boundary, so unreceived lanes read as zero.
  always_comb begin
    asm_next = asm_q;
    case (byte_cnt)
      2'd0:    asm_next[31:24] = bus.ld_byte_i;
      2'd1:    asm_next[23:16] = bus.ld_byte_i;
      2'd2:    asm_next[15:8]  = bus.ld_byte_i;
      default: asm_next[7:0]   = bus.ld_byte_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      word_cnt_o <= '0;
      byte_cnt   <= 2'd0;
      asm_q      <= 32'h0;
      ready_q    <= 1'b1;
      core_rst_o <= 1'b1;
      ld_done_o  <= 1'b0;
      ld_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (full) begin
              // Overflow byte is dropped; only rst leaves this condition.
              state    <= ST_ERR;
              ready_q  <= 1'b0;
              ld_err_o <= 1'b1;
            end else if (bus.ld_last_i) begin
              word_cnt_o <= word_cnt_o + CNT_ONE;
              byte_cnt   <= 2'd0;
              asm_q      <= 32'h0;
              state      <= ST_RUN;
              ready_q    <= 1'b0;
              core_rst_o <= 1'b0;
              ld_done_o  <= 1'b1;
            end else if (byte_cnt == 2'd3) begin
              word_cnt_o <= word_cnt_o + CNT_ONE;
              byte_cnt   <= 2'd0;
              asm_q      <= 32'h0;
            end else begin
              asm_q    <= asm_next;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (reload_i) begin
            state      <= ST_LOAD;
            word_cnt_o <= '0;
            byte_cnt   <= 2'd0;
            asm_q      <= 32'h0;
            ready_q    <= 1'b1;
            core_rst_o <= 1'b1;
            ld_done_o  <= 1'b0;
          end
        end
        default: begin
          state <= ST_ERR;
        end
      endcase
    end
  end

  // Array is not reset: stale entries stay unreachable behind the word count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_cnt_o[DEPTH_LOG2-1:0]] <= asm_next;
    end
  end

  assign rd_idx      = bus.addr_i[DEPTH_LOG2+1:2];
  assign rd_in_range = (bus.addr_i[31:DEPTH_LOG2+2] == '0);
  assign rd_hit      = bus.ce_i && (state == ST_RUN) && rd_in_range &&
                       ({1'b0, rd_idx} < word_cnt_o);
  assign bus.inst_o  = rd_hit ? mem[rd_idx] : 32'h0;
  assign unused_addr = ^bus.addr_i[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed and randomized checks of inst_rom_loader against a byte-list model
// of the loaded program; a second instance with a 4-word ROM covers overflow.
module tb_inst_rom_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic reload0, reload1;
  logic core_rst0, done0, err0;
  logic core_rst1, done1, err1;
  logic [10:0] cnt0;
  logic [2:0]  cnt1;
  logic [1:0]  st0, st1;

  inst_rom_loader_if bus0 ();
  inst_rom_loader_if bus1 ();

  inst_rom_loader #(.DEPTH_LOG2(10)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.slave), .reload_i(reload0),
    .core_rst_o(core_rst0), .ld_done_o(done0), .ld_err_o(err0),
    .word_cnt_o(cnt0), .state_dbg(st0)
  );

  inst_rom_loader #(.DEPTH_LOG2(2)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1.slave), .reload_i(reload1),
    .core_rst_o(core_rst1), .ld_done_o(done1), .ld_err_o(err1),
    .word_cnt_o(cnt1), .state_dbg(st1)
  );

  // ---------------- reference model ----------------
  // m_state: 0 = loading, 1 = running, 2 = overflow error
  int          m_state [2];
  int          m_n     [2];
  int          m_log2  [2];
  logic [7:0]  m_b     [2][0:255];

  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic int exp_cnt(int s);
    if (m_state[s] == 1) return (m_n[s] + 3) / 4;
    return m_n[s] / 4;
  endfunction

  function automatic logic [31:0] exp_word(int s, int k);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      w = {w[23:0], ((4 * k + j) < m_n[s]) ? m_b[s][4 * k + j] : 8'h00};
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_inst(int s, bit ce, logic [31:0] addr);
    longint a;
    a = longint'(addr);
    if (!ce || m_state[s] != 1) return 32'h0;
    if (a >= (longint'(4) << m_log2[s])) return 32'h0;
    if (int'(a / 4) >= exp_cnt(s)) return 32'h0;
    return exp_word(s, int'(a / 4));
  endfunction

  task automatic model_xfer(int s, logic [7:0] b, bit last);
    if (m_state[s] != 0) return;
    if (m_n[s] == 4 * (1 << m_log2[s])) begin
      m_state[s] = 2;
    end else begin
      m_b[s][m_n[s]] = b;
      m_n[s]++;
      if (last) m_state[s] = 1;
    end
  endtask

  task automatic model_reset(int s);
    m_state[s] = 0;
    m_n[s]     = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_inst(int s);
    return (s == 0) ? bus0.inst_o : bus1.inst_o;
  endfunction

  task automatic check_status(int s, string tag);
    if (s == 0) begin
      chk({tag, ".ready"},   32'(bus0.ld_ready_o), 32'(m_state[0] == 0));
      chk({tag, ".core_rst"}, 32'(core_rst0),      32'(m_state[0] != 1));
      chk({tag, ".done"},    32'(done0),           32'(m_state[0] == 1));
      chk({tag, ".err"},     32'(err0),            32'(m_state[0] == 2));
      chk({tag, ".cnt"},     32'(cnt0),            32'(exp_cnt(0)));
    end else begin
      chk({tag, ".ready"},   32'(bus1.ld_ready_o), 32'(m_state[1] == 0));
      chk({tag, ".core_rst"}, 32'(core_rst1),      32'(m_state[1] != 1));
      chk({tag, ".done"},    32'(done1),           32'(m_state[1] == 1));
      chk({tag, ".err"},     32'(err1),            32'(m_state[1] == 2));
      chk({tag, ".cnt"},     32'(cnt1),            32'(exp_cnt(1)));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int s, bit v, logic [7:0] b, bit last);
    if (s == 0) begin
      bus0.ld_valid_i = v; bus0.ld_byte_i = b; bus0.ld_last_i = last;
    end else begin
      bus1.ld_valid_i = v; bus1.ld_byte_i = b; bus1.ld_last_i = last;
    end
  endtask

  task automatic xfer(int s, logic [7:0] b, bit last);
    drive(s, 1'b1, b, last);
    @(posedge clk);
    model_xfer(s, b, last);
    #1;
    drive(s, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
    check_status(s, "xfer");
  endtask

  task automatic reload(int s);
    if (s == 0) reload0 = 1'b1; else reload1 = 1'b1;
    @(posedge clk);
    if (m_state[s] == 1) model_reset(s);
    #1;
    if (s == 0) reload0 = 1'b0; else reload1 = 1'b0;
    check_status(s, "reload");
  endtask

  task automatic do_reset(int s);
    if (s == 0) rst0 = 1'b1; else rst1 = 1'b1;
    #1;
    model_reset(s);
    check_status(s, "async_rst");
    chk("async_rst.inst", get_inst(s), 32'h0);
    #3;
    if (s == 0) rst0 = 1'b0; else rst1 = 1'b0;
    tick();
  endtask

  task automatic set_fetch(int s, bit ce, logic [31:0] addr);
    if (s == 0) begin bus0.ce_i = ce; bus0.addr_i = addr; end
    else begin bus1.ce_i = ce; bus1.addr_i = addr; end
    #1;
  endtask

  task automatic fetch(int s, bit ce, logic [31:0] addr, string tag);
    set_fetch(s, ce, addr);
    exp_q.push_back(exp_inst(s, ce, addr));
    chk(tag, get_inst(s), exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] prog [8];
    logic [31:0] a;
    int n;

    m_log2[0] = 10; m_log2[1] = 2;
    model_reset(0); model_reset(1);
    rst0 = 1'b1; rst1 = 1'b1; reload0 = 1'b0; reload1 = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0); drive(1, 1'b0, 8'h00, 1'b0);
    set_fetch(0, 1'b1, 32'h0); set_fetch(1, 1'b1, 32'h0);
    #11;
    check_status(0, "reset");
    check_status(1, "reset");
    chk("reset.inst", get_inst(0), 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // Two-word program
    prog = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    for (int i = 0; i < 8; i++) xfer(0, prog[i], i == 7);
    chk("prog.cnt", 32'(cnt0), 32'd2);
    chk("prog.core_rst", 32'(core_rst0), 32'd0);
    chk("prog.done", 32'(done0), 32'd1);
    set_fetch(0, 1'b1, 32'h0);       chk("fetch0", get_inst(0), 32'h34011100);
    set_fetch(0, 1'b1, 32'h4);       chk("fetch4", get_inst(0), 32'h34020020);
    set_fetch(0, 1'b1, 32'h7);       chk("fetch7_lowbits", get_inst(0), 32'h34020020);
    set_fetch(0, 1'b1, 32'h8);       chk("fetch8_beyond", get_inst(0), 32'h0);
    set_fetch(0, 1'b0, 32'h0);       chk("fetch_ce0", get_inst(0), 32'h0);
    set_fetch(0, 1'b1, 32'h1000);    chk("fetch_hi", get_inst(0), 32'h0);
    fetch(0, 1'b1, 32'h0, "fetch0_model");

    // Valid while running is not a transfer
    drive(0, 1'b1, 8'h5A, 1'b1); tick(); drive(0, 1'b0, 8'h00, 1'b0);
    check_status(0, "run_valid");

    // Reload, one zero word
    reload(0);
    set_fetch(0, 1'b1, 32'h0);       chk("reload.inst", get_inst(0), 32'h0);
    reload(0);                        // ignored while loading
    for (int i = 0; i < 4; i++) xfer(0, 8'h00, i == 3);
    chk("zero.cnt", 32'(cnt0), 32'd1);
    set_fetch(0, 1'b1, 32'h4);       chk("zero.stale", get_inst(0), 32'h0);

    // Partial last word, with reload pulse mid-load
    reload(0);
    xfer(0, 8'hAA, 1'b0); xfer(0, 8'hBB, 1'b0);
    reload(0);
    xfer(0, 8'hCC, 1'b0); xfer(0, 8'hDD, 1'b0); xfer(0, 8'hEE, 1'b1);
    chk("part.cnt", 32'(cnt0), 32'd2);
    set_fetch(0, 1'b1, 32'h0);       chk("part.w0", get_inst(0), 32'hAABBCCDD);
    set_fetch(0, 1'b1, 32'h4);       chk("part.w1", get_inst(0), 32'hEE000000);

    // Reset mid-load discards the partial word
    reload(0);
    for (int i = 0; i < 6; i++) xfer(0, 8'(8'h11 * (i + 1)), 1'b0);
    do_reset(0);
    xfer(0, 8'h9A, 1'b0); xfer(0, 8'hBC, 1'b0); xfer(0, 8'hDE, 1'b0); xfer(0, 8'hF0, 1'b1);
    chk("rstmid.cnt", 32'(cnt0), 32'd1);
    set_fetch(0, 1'b1, 32'h0);       chk("rstmid.w0", get_inst(0), 32'h9ABCDEF0);
    set_fetch(0, 1'b1, 32'h4);       chk("rstmid.w1", get_inst(0), 32'h0);

    // Overflow on the 4-word instance
    for (int i = 0; i < 16; i++) xfer(1, 8'($urandom), 1'b0);
    chk("ovf.cnt16", 32'(cnt1), 32'd4);
    xfer(1, 8'h77, 1'b0);
    chk("ovf.err", 32'(err1), 32'd1);
    chk("ovf.ready", 32'(bus1.ld_ready_o), 32'd0);
    chk("ovf.core_rst", 32'(core_rst1), 32'd1);
    reload(1);
    chk("ovf.reload_err", 32'(err1), 32'd1);
    do_reset(1);
    for (int i = 0; i < 16; i++) xfer(1, 8'($urandom), i == 15);
    fetch(1, 1'b1, 32'hC, "full.w3");
    fetch(1, 1'b1, 32'hF, "full.w3_low");
    set_fetch(1, 1'b1, 32'h10);      chk("full.hi", get_inst(1), 32'h0);

    // Randomized programs and fetches
    for (int it = 0; it < 10; it++) begin
      if (m_state[0] == 1) reload(0);
      n = $urandom_range(1, 48);
      for (int i = 0; i < n; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          drive(0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
          tick();
        end
        xfer(0, 8'($urandom), i == n - 1);
      end
      for (int f = 0; f < 12; f++) begin
        case ($urandom_range(0, 3))
          0:       a = $urandom;
          1:       a = 32'h1000 | 32'($urandom_range(0, 15));
          default: a = 32'($urandom_range(0, 4 * exp_cnt(0) + 11));
        endcase
        fetch(0, $urandom_range(0, 3) != 0, a, "rand.fetch");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
